trace_buffer: RTL

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/trace_buffer.sv
// Trace capture FIFO: records non-NOP {ts, zero_flag, op_code, alu_out}; optional timestamp via TRACE_TIMESTAMP_EN.
// Latency: a capture is visible at rd_data/rd_valid one cycle after its capture edge.
// Backpressure: rd_valid/rd_ready pop; when full, a capture is dropped (or freezes in HALT if stop_on_full).
module trace_buffer #(
    parameter int VALUE_WIDTH  = 8,
    parameter int OPCODE_WIDTH = 4,
    parameter int DEPTH        = 16,
    parameter int NOP_CODE     = 0,
    parameter int TS_WIDTH     = 16,
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W     = TS_WIDTH + 1 + OPCODE_WIDTH + VALUE_WIDTH
`else
    localparam int ENTRY_W     = 1 + OPCODE_WIDTH + VALUE_WIDTH
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trace_en,
    input  logic                      stop_on_full,
    input  logic [OPCODE_WIDTH-1:0]   op_code,
    input  logic [VALUE_WIDTH-1:0]    alu_out,
    input  logic                      zero_flag,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [ENTRY_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [7:0]                drop_count,
    input  logic                      clear
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [OPCODE_WIDTH-1:0] NOP = OPCODE_WIDTH'(NOP_CODE);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t             state;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               full;
    logic               capture;
    logic               pop;
    logic               do_write;
    logic               lost;
    logic [ENTRY_W-1:0] entry;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign entry = {ts, zero_flag, op_code, alu_out};
`else
    assign entry = {zero_flag, op_code, alu_out};
`endif

    assign rd_valid = (count != '0);
    assign full     = (count == (AW + 1)'(DEPTH));
    assign capture  = (state == RUN) && (op_code != NOP);
    assign pop      = rd_valid && rd_ready;
    // A simultaneous pop frees the slot, so a capture into a full FIFO still lands.
    assign do_write = capture && (!full || pop);
    assign lost     = capture && full && !pop;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_write && !clear) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (lost) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
            case (state)
                IDLE: if (trace_en) state <= RUN;
                RUN: begin
                    if (!trace_en) begin
                        state <= IDLE;
                    end else if (lost && stop_on_full) begin
                        state <= HALT;
                    end
                end
                HALT: if (!trace_en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
